// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit.
//   - opcode / funct field values recognised by the decoder
//   - 3-bit ALU operation codes (zero-extended to ALU_CTRL_W at the top)
//   - FSM state encoding and the coarse instruction classes used by DECODE
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_EXEC, S_RWB, S_BRANCH, S_IEXEC, S_IWB, S_JUMP, S_TRAP
    } state_t;

    typedef enum logic [2:0] {
        C_MEM, C_RTYPE, C_BRANCH, C_IMM, C_JUMP, C_ILLEGAL
    } op_class_t;

endpackage

// File: rtl/mips_alu_decode.sv
// Combinational instruction decoder for the multicycle control unit.
// Ports:
//   i_op, i_funct    IR opcode and function fields
//   o_alu_ctrl       ALU code for the execute step (R-type: from funct,
//                    immediate ops: from opcode, otherwise AND/000)
//   o_sign_ext       immediate extension mode (0 only for andi/ori)
//   o_op_class       instruction class that steers DECODE
//   o_funct_legal    funct is one of the supported R-type operations
module mips_alu_decode
    import mips_ctrl_pkg::*;
#(
    parameter int HAS_ANDI = 1,
    parameter int HAS_SLTI = 1
) (
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_ctrl,
    output logic       o_sign_ext,
    output op_class_t  o_op_class,
    output logic       o_funct_legal
);

    logic [2:0] w_fn_code;

    always_comb begin
        w_fn_code     = ALU_AND;
        o_funct_legal = 1'b1;
        case (i_funct)
            FN_ADD:  w_fn_code = ALU_ADD;
            FN_SUB:  w_fn_code = ALU_SUB;
            FN_AND:  w_fn_code = ALU_AND;
            FN_OR:   w_fn_code = ALU_OR;
            FN_SLT:  w_fn_code = ALU_SLT;
            default: o_funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        o_alu_ctrl = ALU_AND;
        o_sign_ext = 1'b1;
        o_op_class = C_ILLEGAL;
        case (i_op)
            OP_RTYPE: begin
                o_op_class = C_RTYPE;
                o_alu_ctrl = w_fn_code;
            end
            OP_LW, OP_SW:   o_op_class = C_MEM;
            OP_BEQ, OP_BNE: o_op_class = C_BRANCH;
            OP_J:           o_op_class = C_JUMP;
            OP_ADDI: begin
                o_op_class = C_IMM;
                o_alu_ctrl = ALU_ADD;
            end
            OP_ORI: begin
                o_op_class = C_IMM;
                o_alu_ctrl = ALU_OR;
                o_sign_ext = 1'b0;
            end
            OP_SLTI: begin
                if (HAS_SLTI != 0) begin
                    o_op_class = C_IMM;
                    o_alu_ctrl = ALU_SLT;
                end
            end
            OP_ANDI: begin
                if (HAS_ANDI != 0) begin
                    o_op_class = C_IMM;
                    o_alu_ctrl = ALU_AND;
                    o_sign_ext = 1'b0;
                end
            end
            default: o_op_class = C_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory and writeback, with memory wait-states, run/halt at instruction
// boundaries, a sticky illegal-op trap and a retired-instruction counter.
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_run                      1: execute, 0: halt at next retire boundary
//   i_op, i_funct              IR fields (valid from DECODE onward)
//   i_mem_ready                memory completes access this cycle
//   o_pc_write .. o_alu_ctrl   datapath controls decoded from state
//   o_illegal_op               sticky trap flag
//   o_busy                     state != IDLE
//   o_instr_retired            completed-instruction count (wraps)
//
// state   | meaning
// IDLE    | halted, all controls low
// FETCH   | read instruction at PC, PC+4 when memory ready
// DECODE  | register read, branch target precompute
// MEMADR  | effective address A + imm
// MEMRD   | load read, waits for memory
// MEMWB   | load result to rt (retire)
// MEMWR   | store write, waits for memory (retire)
// EXEC    | R-type ALU op from funct
// RWB     | R-type result to rd (retire)
// BRANCH  | compare and conditional PC load (retire)
// IEXEC   | immediate ALU op
// IWB     | immediate result to rt (retire)
// JUMP    | PC load from jump target (retire)
// TRAP    | unknown op/funct, locked until reset
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3,
    parameter int CNT_W      = 32,
    parameter int HAS_ANDI   = 1,
    parameter int HAS_SLTI   = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_run,
    input  logic [5:0]            i_op,
    input  logic [5:0]            i_funct,
    input  logic                  i_mem_ready,
    output logic                  o_pc_write,
    output logic                  o_pc_write_cond,
    output logic                  o_is_bne,
    output logic                  o_iord,
    output logic                  o_mem_rd,
    output logic                  o_mem_wr,
    output logic                  o_ir_write,
    output logic                  o_reg_dst,
    output logic                  o_mem_to_reg,
    output logic                  o_reg_wr,
    output logic                  o_alu_src_a,
    output logic [1:0]            o_alu_src_b,
    output logic                  o_sign_ext,
    output logic [1:0]            o_pc_src,
    output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
    output logic                  o_illegal_op,
    output logic                  o_busy,
    output logic [CNT_W-1:0]      o_instr_retired
);

    state_t             r_state;
    state_t             w_next;
    logic               w_retire;
    logic [CNT_W-1:0]   r_instr_retired;
    logic               r_illegal_op;
    logic [2:0]         w_dec_alu;
    logic               w_dec_sext;
    op_class_t          w_dec_class;
    logic               w_funct_legal;
    logic [2:0]         w_alu;

    mips_alu_decode #(
        .HAS_ANDI (HAS_ANDI),
        .HAS_SLTI (HAS_SLTI)
    ) u_alu_decode (
        .i_op          (i_op),
        .i_funct       (i_funct),
        .o_alu_ctrl    (w_dec_alu),
        .o_sign_ext    (w_dec_sext),
        .o_op_class    (w_dec_class),
        .o_funct_legal (w_funct_legal)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= S_IDLE;
            r_instr_retired <= '0;
            r_illegal_op    <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_retire)
                r_instr_retired <= r_instr_retired + CNT_W'(1);
            // Raised on entry so the flag is already visible in the first TRAP cycle.
            if (w_next == S_TRAP)
                r_illegal_op <= 1'b1;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_IDLE:   if (i_run) w_next = S_FETCH;
            S_FETCH:  if (i_mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (w_dec_class)
                    C_MEM:    w_next = S_MEMADR;
                    C_RTYPE:  w_next = S_EXEC;
                    C_BRANCH: w_next = S_BRANCH;
                    C_IMM:    w_next = S_IEXEC;
                    C_JUMP:   w_next = S_JUMP;
                    default:  w_next = S_TRAP;
                endcase
            end
            S_MEMADR: w_next = (i_op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (i_mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (i_mem_ready) w_retire = 1'b1;
            S_EXEC:   w_next = w_funct_legal ? S_RWB : S_TRAP;
            S_MEMWB, S_RWB, S_BRANCH, S_IWB, S_JUMP: w_retire = 1'b1;
            S_IEXEC:  w_next = S_IWB;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_IDLE;
        endcase
        if (w_retire)
            w_next = i_run ? S_FETCH : S_IDLE;
    end

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_is_bne        = 1'b0;
        o_iord          = 1'b0;
        o_mem_rd        = 1'b0;
        o_mem_wr        = 1'b0;
        o_ir_write      = 1'b0;
        o_reg_dst       = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_wr        = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_sign_ext      = 1'b1;
        o_pc_src        = 2'b00;
        w_alu           = ALU_AND;
        case (r_state)
            S_IDLE:   o_sign_ext = 1'b0;
            S_FETCH: begin
                o_mem_rd    = 1'b1;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
                o_alu_src_b = 2'b01;
                w_alu       = ALU_ADD;
            end
            S_DECODE: begin
                o_alu_src_b = 2'b11;
                w_alu       = ALU_ADD;
            end
            S_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                w_alu       = ALU_ADD;
            end
            S_MEMRD: begin
                o_iord   = 1'b1;
                o_mem_rd = 1'b1;
            end
            S_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_wr     = 1'b1;
            end
            S_MEMWR: begin
                o_iord   = 1'b1;
                o_mem_wr = 1'b1;
            end
            S_EXEC: begin
                o_alu_src_a = 1'b1;
                w_alu       = w_dec_alu;
            end
            S_RWB: begin
                o_reg_dst = 1'b1;
                o_reg_wr  = 1'b1;
            end
            S_BRANCH: begin
                o_alu_src_a     = 1'b1;
                w_alu           = ALU_SUB;
                o_pc_src        = 2'b01;
                o_pc_write_cond = 1'b1;
                o_is_bne        = (i_op == OP_BNE);
            end
            S_IEXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                w_alu       = w_dec_alu;
                o_sign_ext  = w_dec_sext;
            end
            S_IWB: begin
                o_reg_wr   = 1'b1;
                o_sign_ext = w_dec_sext;
            end
            S_JUMP: begin
                o_pc_src   = 2'b10;
                o_pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_alu_ctrl      = ALU_CTRL_W'(w_alu);
    assign o_illegal_op    = r_illegal_op;
    assign o_busy          = (r_state != S_IDLE);
    assign o_instr_retired = r_instr_retired;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       is_bne;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       sign_ext;
        logic [1:0] pc_src;
        logic [2:0] alu_ctrl;
        logic       illegal_op;
        logic       busy;
        logic [3:0] retired;
    } obs_t;

    typedef enum {P_IDLE, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                  P_EXEC, P_RWB, P_BRANCH, P_IEXEC, P_IWB, P_JUMP, P_TRAP} phase_t;

    logic       clk = 1'b0;
    logic       rst_n, run, rdy;
    logic [5:0] op, funct;
    logic       pc_write, pc_write_cond, is_bne, iord, mem_rd, mem_wr, ir_write;
    logic       reg_dst, mem_to_reg, reg_wr, alu_src_a, sign_ext, illegal_op, busy;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] retired;

    obs_t   act, exp_cur;
    phase_t chk_ph;
    bit     chk_en = 1'b0;
    int     n_chk = 0;
    int     n_bad = 0;
    logic [3:0] m_cnt = 4'd0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.ALU_CTRL_W(3), .CNT_W(4), .HAS_ANDI(1), .HAS_SLTI(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_op(op), .i_funct(funct),
        .i_mem_ready(rdy), .o_pc_write(pc_write), .o_pc_write_cond(pc_write_cond),
        .o_is_bne(is_bne), .o_iord(iord), .o_mem_rd(mem_rd), .o_mem_wr(mem_wr),
        .o_ir_write(ir_write), .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg),
        .o_reg_wr(reg_wr), .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b),
        .o_sign_ext(sign_ext), .o_pc_src(pc_src), .o_alu_ctrl(alu_ctrl),
        .o_illegal_op(illegal_op), .o_busy(busy), .o_instr_retired(retired));

    assign act = {pc_write, pc_write_cond, is_bne, iord, mem_rd, mem_wr, ir_write,
                  reg_dst, mem_to_reg, reg_wr, alu_src_a, alu_src_b, sign_ext, pc_src,
                  alu_ctrl, illegal_op, busy, retired};

    // R-type funct -> ALU code; unsupported funct leaves the ALU at 000.
    function automatic logic [2:0] fn_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b000;
        endcase
    endfunction

    function automatic bit fn_ok(input logic [5:0] f);
        return (f == 6'b100000) || (f == 6'b100010) || (f == 6'b100100) ||
               (f == 6'b100101) || (f == 6'b101010);
    endfunction

    // Immediate op -> {sign_ext, alu code}.
    function automatic logic [3:0] imm_info(input logic [5:0] o);
        case (o)
            6'b001000: return {1'b1, 3'b010};
            6'b001010: return {1'b1, 3'b111};
            6'b001100: return {1'b0, 3'b000};
            default:   return {1'b0, 3'b001};
        endcase
    endfunction

    function automatic obs_t model(input phase_t ph);
        obs_t e;
        logic [3:0] ii;
        e = '0;
        e.busy = 1'b1;
        e.sign_ext = 1'b1;
        e.retired = m_cnt;
        ii = imm_info(op);
        case (ph)
            P_IDLE:   begin e.busy = 1'b0; e.sign_ext = 1'b0; end
            P_FETCH:  begin e.mem_rd = 1'b1; e.ir_write = rdy; e.pc_write = rdy;
                            e.alu_src_b = 2'b01; e.alu_ctrl = 3'b010; end
            P_DECODE: begin e.alu_src_b = 2'b11; e.alu_ctrl = 3'b010; end
            P_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; e.alu_ctrl = 3'b010; end
            P_MEMRD:  begin e.iord = 1'b1; e.mem_rd = 1'b1; end
            P_MEMWB:  begin e.mem_to_reg = 1'b1; e.reg_wr = 1'b1; end
            P_MEMWR:  begin e.iord = 1'b1; e.mem_wr = 1'b1; end
            P_EXEC:   begin e.alu_src_a = 1'b1; e.alu_ctrl = fn_alu(funct); end
            P_RWB:    begin e.reg_dst = 1'b1; e.reg_wr = 1'b1; end
            P_BRANCH: begin e.alu_src_a = 1'b1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01;
                            e.pc_write_cond = 1'b1; e.is_bne = (op == 6'b000101); end
            P_IEXEC:  begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
                            e.alu_ctrl = ii[2:0]; e.sign_ext = ii[3]; end
            P_IWB:    begin e.reg_wr = 1'b1; e.sign_ext = ii[3]; end
            P_JUMP:   begin e.pc_src = 2'b10; e.pc_write = 1'b1; end
            P_TRAP:   e.illegal_op = 1'b1;
            default:  ;
        endcase
        return e;
    endfunction

    task automatic check(input string tag, input obs_t a, input obs_t e);
        n_chk++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s t=%0t got=%h want=%h", tag, $time, a, e);
        end
    endtask

    task automatic check_lit(input string tag, input logic [7:0] a, input logic [7:0] e);
        n_chk++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, a, e);
        end
    endtask

    always @(negedge clk)
        if (chk_en) check(chk_ph.name(), act, exp_cur);

    task automatic step(input phase_t ph);
        exp_cur = model(ph);
        chk_ph  = ph;
        chk_en  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input phase_t ph);
        step(ph);
        m_cnt = m_cnt + 4'd1;
    endtask

    // Runs one instruction starting in FETCH; mem_ready is 1 outside waits
    // so it is also exercised where it must be ignored.
    task automatic do_instr(input logic [5:0] o, input logic [5:0] f,
                            input int fwait, input int mwait, input bit drop);
        op = o;
        funct = f;
        rdy = 1'b0;
        repeat (fwait) step(P_FETCH);
        rdy = 1'b1;
        step(P_FETCH);
        step(P_DECODE);
        case (o)
            6'b100011, 6'b101011: begin
                step(P_MEMADR);
                rdy = 1'b0;
                repeat (mwait) step(o == 6'b100011 ? P_MEMRD : P_MEMWR);
                rdy = 1'b1;
                if (o == 6'b100011) begin
                    step(P_MEMRD);
                    retire(P_MEMWB);
                end else
                    retire(P_MEMWR);
            end
            6'b000000: begin
                if (drop) run = 1'b0;
                step(P_EXEC);
                if (fn_ok(f)) retire(P_RWB);
                else step(P_TRAP);
            end
            6'b000100, 6'b000101: retire(P_BRANCH);
            6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
                step(P_IEXEC);
                retire(P_IWB);
            end
            6'b000010: retire(P_JUMP);
            default: step(P_TRAP);
        endcase
    endtask

    task automatic reset_dut();
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        m_cnt = 4'd0;
        check("reset", act, model(P_IDLE));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; run = 1'b0; rdy = 1'b0; op = 6'd0; funct = 6'd0;
        #12;
        check("por", act, model(P_IDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;
        run = 1'b1;
        step(P_IDLE);

        // add
        do_instr(6'b000000, 6'b100000, 0, 0, 0);
        check_lit("cnt_after_add", {4'd0, retired}, 8'd1);

        // lw aborted by reset while waiting in MEMRD
        op = 6'b100011; funct = 6'd0; rdy = 1'b1;
        step(P_FETCH); step(P_DECODE); step(P_MEMADR);
        rdy = 1'b0;
        step(P_MEMRD); step(P_MEMRD);
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        m_cnt = 4'd0;
        check("abort", act, model(P_IDLE));
        check_lit("abort_cnt", {4'd0, retired}, 8'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run = 1'b1;
        step(P_IDLE);

        do_instr(6'b100011, 6'd0, 1, 3, 0);          // lw, 3 wait cycles in MEMRD
        do_instr(6'b101011, 6'd0, 0, 2, 0);          // sw
        do_instr(6'b000101, 6'd0, 0, 0, 0);          // bne
        do_instr(6'b000100, 6'd0, 0, 0, 0);          // beq
        do_instr(6'b001000, 6'd0, 0, 0, 0);          // addi
        do_instr(6'b001010, 6'd0, 0, 0, 0);          // slti
        do_instr(6'b001100, 6'd0, 0, 0, 0);          // andi
        do_instr(6'b000010, 6'd0, 0, 0, 0);          // j
        do_instr(6'b000000, 6'b100010, 0, 0, 0);     // sub
        do_instr(6'b000000, 6'b100100, 2, 0, 0);     // and
        do_instr(6'b000000, 6'b101010, 0, 0, 0);     // slt
        do_instr(6'b000000, 6'b100101, 0, 0, 1);     // or, run dropped in EXEC
        step(P_IDLE);
        step(P_IDLE);
        check_lit("halt_cnt", {4'd0, retired}, 8'd12);

        // 16 retires wrap a 4-bit counter
        reset_dut();
        run = 1'b1;
        step(P_IDLE);
        repeat (15) do_instr(6'b000010, 6'd0, 0, 0, 0);
        check_lit("cnt_15", {4'd0, retired}, 8'd15);
        do_instr(6'b000010, 6'd0, 0, 0, 0);
        check_lit("cnt_wrap", {4'd0, retired}, 8'd0);

        // ori then unknown opcode
        reset_dut();
        run = 1'b1;
        step(P_IDLE);
        do_instr(6'b001101, 6'd0, 0, 0, 0);
        do_instr(6'b111111, 6'd0, 0, 0, 0);
        rdy = 1'b0; step(P_TRAP);
        rdy = 1'b1; run = 1'b0; step(P_TRAP);
        check_lit("trap_cnt", {4'd0, retired}, 8'd1);
        check_lit("trap_flag", {7'd0, illegal_op}, 8'd1);

        // unknown funct traps after EXEC
        reset_dut();
        check_lit("flag_cleared", {7'd0, illegal_op}, 8'd0);
        run = 1'b1;
        step(P_IDLE);
        do_instr(6'b000000, 6'b111111, 0, 0, 0);
        step(P_TRAP);
        check_lit("fn_trap_cnt", {4'd0, retired}, 8'd0);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
